// File: rtl/video_timing_gen.sv
// Pixel-rate raster timing generator: h/v counters, blank/sync windows, strobes and scroll accumulator.
// Optional interlace (odd field one line longer, half-line vsync) under `VIDEO_TIMING_INTERLACE_EN.
module video_timing_gen #(
    parameter int H_TOTAL   = 640,
    parameter int V_TOTAL   = 312,
    parameter int HBL_START = 310,
    parameter int HBL_END   = 440,
    parameter int HS_START  = 336,
    parameter int HS_END    = 368,
    parameter int VBL_START = 306,
    parameter int VBL_END   = 2,
    parameter int VS_START  = 308,
    parameter int VS_END    = 0,
    parameter int VVC_STEP  = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce_pix,
    output logic [9:0] hc,
    output logic [8:0] vc,
    output logic [9:0] vvc,
    output logic       hblank,
    output logic       vblank,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic       sol,
    output logic       sof,
    output logic       field
);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
    localparam logic [9:0] HBL_S    = 10'(HBL_START);
    localparam logic [9:0] HBL_E    = 10'(HBL_END);
    localparam logic [9:0] HS_S     = 10'(HS_START);
    localparam logic [9:0] HS_E     = 10'(HS_END);
    localparam logic [9:0] VBL_S    = 10'(VBL_START);
    localparam logic [9:0] VBL_E    = 10'(VBL_END);
    localparam logic [9:0] VS_S     = 10'(VS_START);
    localparam logic [9:0] VS_E     = 10'(VS_END);
    localparam logic [9:0] VVC_INC  = 10'(VVC_STEP);

    // Window rule: ordinary range, range wrapping through zero, or empty when S==E.
    function automatic logic in_window(input logic [9:0] x, input logic [9:0] s, input logic [9:0] e);
        logic r;
        if (s < e) begin
            r = (x >= s) && (x < e);
        end else if (s > e) begin
            r = (x >= s) || (x < e);
        end else begin
            r = 1'b0;
        end
        return r;
    endfunction

`ifdef VIDEO_TIMING_INTERLACE_EN
    localparam logic [8:0] V_LAST_ODD = 9'(V_TOTAL);
    localparam logic [9:0] H_HALF     = 10'(H_TOTAL / 2);

    // Odd-field vsync: same line window but both edges shifted to mid-line.
    function automatic logic half_window(input logic [9:0] y, input logic [9:0] x);
        logic after_s;
        logic before_e;
        logic r;
        after_s  = (y > VS_S) || ((y == VS_S) && (x >= H_HALF));
        before_e = (y < VS_E) || ((y == VS_E) && (x < H_HALF));
        if (VS_S < VS_E) begin
            r = after_s && before_e;
        end else if (VS_S > VS_E) begin
            r = after_s || before_e;
        end else begin
            r = 1'b0;
        end
        return r;
    endfunction
`endif

    logic [9:0] hc_n;
    logic [8:0] vc_n;
    logic [9:0] vvc_n;
    logic       field_n;
    logic [8:0] v_last;
    logic       hblank_n;
    logic       vblank_n;
    logic       hsync_n;
    logic       vsync_n;

    // Last line index of the current field.
    always_comb begin
        v_last = V_LAST;
`ifdef VIDEO_TIMING_INTERLACE_EN
        if (field) begin
            v_last = V_LAST_ODD;
        end else begin
            v_last = V_LAST;
        end
`endif
    end

    // Next counter values assuming one pixel advance.
    always_comb begin
        hc_n    = hc;
        vc_n    = vc;
        vvc_n   = vvc;
        field_n = field;
        if (hc == H_LAST) begin
            hc_n = 10'd0;
            if (vc == v_last) begin
                vc_n  = 9'd0;
                vvc_n = vvc + VVC_INC;
`ifdef VIDEO_TIMING_INTERLACE_EN
                field_n = ~field;
`else
                field_n = 1'b0;
`endif
            end else begin
                vc_n = vc + 9'd1;
            end
        end else begin
            hc_n = hc + 10'd1;
        end
    end

    // Flags evaluated on the next counter values so they register alongside them.
    always_comb begin
        hblank_n = in_window(hc_n, HBL_S, HBL_E);
        hsync_n  = in_window(hc_n, HS_S, HS_E);
        vblank_n = in_window({1'b0, vc_n}, VBL_S, VBL_E);
        vsync_n  = in_window({1'b0, vc_n}, VS_S, VS_E);
`ifdef VIDEO_TIMING_INTERLACE_EN
        if (field_n) begin
            vsync_n = half_window({1'b0, vc_n}, hc_n);
        end else begin
            vsync_n = in_window({1'b0, vc_n}, VS_S, VS_E);
        end
`endif
    end

    // State and output registers; strobes exist only on enabled clocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            hc     <= 10'd0;
            vc     <= 9'd0;
            vvc    <= 10'd0;
            field  <= 1'b0;
            hblank <= 1'b0;
            hsync  <= 1'b0;
            vblank <= 1'b1;
            vsync  <= 1'b0;
            de     <= 1'b0;
            sol    <= 1'b0;
            sof    <= 1'b0;
        end else if (ce_pix) begin
            hc     <= hc_n;
            vc     <= vc_n;
            vvc    <= vvc_n;
            field  <= field_n;
            hblank <= hblank_n;
            hsync  <= hsync_n;
            vblank <= vblank_n;
            vsync  <= vsync_n;
            de     <= ~hblank_n & ~vblank_n;
            sol    <= (hc_n == 10'd0);
            sof    <= (hc_n == 10'd0) && (vc_n == 9'd0);
        end else begin
            sol    <= 1'b0;
            sof    <= 1'b0;
        end
    end

endmodule
